// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer: runs ROM-described cpu test programs back to back and reports pass/fail
module cpu_test_sequencer #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int NUM_TESTS  = 4,
  parameter int MAX_PROG   = 16,
  parameter int MAX_CHECKS = 8,
  parameter int RUN_CYCLES = 10,
  localparam int STRIDE = 1 + MAX_PROG + 2 * MAX_CHECKS,
  localparam int TV_AW  = $clog2(NUM_TESTS * STRIDE),
  localparam int IA_W   = $clog2(IMEM_DEPTH),
  localparam int FC_W   = $clog2(NUM_TESTS * MAX_CHECKS + 1),
  localparam int TW     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic [TV_AW-1:0] tv_addr_o,
  input  logic [XLEN-1:0]  tv_data_i,
  output logic             cpu_reset_o,
  output logic             imem_we_o,
  output logic [IA_W-1:0]  imem_waddr_o,
  output logic [XLEN-1:0]  imem_wdata_o,
  output logic [4:0]       rf_raddr_o,
  input  logic [XLEN-1:0]  rf_rdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [TW-1:0]    cur_test_o,
  output logic [FC_W-1:0]  fail_count_o,
  output logic [TW-1:0]    fail_test_o,
  output logic [4:0]       fail_reg_o,
  output logic [XLEN-1:0]  fail_got_o,
  output logic [XLEN-1:0]  fail_exp_o
);
  localparam int M1   = (IMEM_DEPTH > RUN_CYCLES) ? IMEM_DEPTH : RUN_CYCLES;
  localparam int M2   = (MAX_PROG > MAX_CHECKS) ? MAX_PROG + 1 : MAX_CHECKS + 1;
  localparam int CW   = $clog2(((M1 > M2) ? M1 : M2) + 1);
  localparam int PLW  = $clog2(MAX_PROG + 1);
  localparam int CCW  = $clog2(MAX_CHECKS + 1);
  typedef enum logic [2:0] {IDLE, HDR, CLEAR, LOAD, RUN, CHECK, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic [PLW-1:0]   plen_q, plen_d;
  logic [CCW-1:0]   ccnt_q, ccnt_d;
  logic [4:0]       ridx_q, ridx_d;
  logic [TW-1:0]    cur_q, cur_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  logic [TW-1:0]    ft_q, ft_d;
  logic [4:0]       freg_q, freg_d;
  logic [XLEN-1:0]  fgot_q, fgot_d, fexp_q, fexp_d;
  logic [TV_AW-1:0] base;
  assign base         = TV_AW'(cur_q) * TV_AW'(STRIDE);
  assign cpu_reset_o  = state_q inside {IDLE, HDR, CLEAR, LOAD};
  assign busy_o       = !(state_q inside {IDLE, DONE});
  assign done_o       = state_q == DONE;
  assign pass_o       = done_o && fc_q == '0;
  assign cur_test_o   = cur_q;
  assign fail_count_o = fc_q;
  assign fail_test_o  = ft_q;
  assign fail_reg_o   = freg_q;
  assign fail_got_o   = fgot_q;
  assign fail_exp_o   = fexp_q;
  // next-state, ROM/imem/regfile addressing and result bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    phase_d = phase_q;
    plen_d = plen_q;
    ccnt_d = ccnt_q;
    ridx_d = ridx_q;
    cur_d = cur_q;
    fc_d = fc_q;
    ft_d = ft_q;
    freg_d = freg_q;
    fgot_d = fgot_q;
    fexp_d = fexp_q;
    tv_addr_o = '0;
    imem_we_o = 1'b0;
    imem_waddr_o = '0;
    imem_wdata_o = '0;
    rf_raddr_o = '0;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = HDR;
        cur_d = '0;
        fc_d = '0;
        ft_d = '0;
        freg_d = '0;
        fgot_d = '0;
        fexp_d = '0;
      end
      HDR: begin
        tv_addr_o = base;
        plen_d = (tv_data_i[31:16] > 16'(MAX_PROG)) ? PLW'(MAX_PROG) : PLW'(tv_data_i[31:16]);
        ccnt_d = (tv_data_i[15:0] > 16'(MAX_CHECKS)) ? CCW'(MAX_CHECKS) : CCW'(tv_data_i[15:0]);
        cnt_d = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        imem_we_o = 1'b1;
        imem_waddr_o = IA_W'(cnt_q);
        imem_wdata_o = XLEN'(32'h0000_0013);
        cnt_d = (cnt_q == CW'(IMEM_DEPTH - 1)) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(IMEM_DEPTH - 1)) state_d = (plen_q != '0) ? LOAD : RUN;
      end
      LOAD: begin
        tv_addr_o = base + TV_AW'(cnt_q) + TV_AW'(1);
        imem_we_o = 1'b1;
        imem_waddr_o = IA_W'(cnt_q);
        imem_wdata_o = tv_data_i;
        cnt_d = (cnt_q + CW'(1) == CW'(plen_q)) ? '0 : cnt_q + CW'(1);
        if (cnt_q + CW'(1) == CW'(plen_q)) state_d = RUN;
      end
      RUN: begin
        phase_d = 1'b0;
        cnt_d = (cnt_q == CW'(RUN_CYCLES - 1)) ? '0 : cnt_q + CW'(1);
        if (cnt_q == CW'(RUN_CYCLES - 1)) state_d = (ccnt_q != '0) ? CHECK : NEXT;
      end
      CHECK: begin
        tv_addr_o = base + TV_AW'(1 + MAX_PROG) + TV_AW'({cnt_q, phase_q});
        phase_d = !phase_q;
        if (!phase_q) ridx_d = tv_data_i[4:0];
        else begin
          rf_raddr_o = ridx_q;
          if (rf_rdata_i != tv_data_i) begin
            fc_d = (&fc_q) ? fc_q : fc_q + FC_W'(1);
            if (fc_q == '0) begin
              ft_d = cur_q;
              freg_d = ridx_q;
              fgot_d = rf_rdata_i;
              fexp_d = tv_data_i;
            end
          end
          cnt_d = (cnt_q + CW'(1) == CW'(ccnt_q)) ? '0 : cnt_q + CW'(1);
          if (cnt_q + CW'(1) == CW'(ccnt_q)) state_d = NEXT;
        end
      end
      NEXT: begin
        state_d = (cur_q == TW'(NUM_TESTS - 1)) ? DONE : HDR;
        cur_d = (cur_q == TW'(NUM_TESTS - 1)) ? cur_q : cur_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      phase_q <= 1'b0;
      plen_q <= '0;
      ccnt_q <= '0;
      ridx_q <= '0;
      cur_q <= '0;
      fc_q <= '0;
      ft_q <= '0;
      freg_q <= '0;
      fgot_q <= '0;
      fexp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      plen_q <= plen_d;
      ccnt_q <= ccnt_d;
      ridx_q <= ridx_d;
      cur_q <= cur_d;
      fc_q <= fc_d;
      ft_q <= ft_d;
      freg_q <= freg_d;
      fgot_q <= fgot_d;
      fexp_q <= fexp_d;
    end
  end
endmodule

// File: doc/cpu_test_sequencer.md
Name: cpu_test_sequencer

Overview:
- Self-checking test sequencer that sits beside the cpu. Runs NUM_TESTS programs back to back and reports pass/fail.
- Each test follows the same steps:
  - hold the cpu in reset;
  - NOP-fill, then load, instruction memory through a write port;
  - release reset for a fixed cycle budget;
  - read back and compare architectural registers through a register-file read port.
- Test programs and expected values come from an external test-vector ROM, so programs are not hard-coded.

Parameters:
- XLEN, 32, data/instruction width
- IMEM_DEPTH, 64, instruction memory words; all are NOP-filled before each load
- NUM_TESTS, 4, number of test descriptors run per start
- MAX_PROG, 16, max instructions per test; header prog_len is clamped to this
- MAX_CHECKS, 8, max register checks per test; header check_cnt is clamped to this
- RUN_CYCLES, 10, cycles the cpu runs per test
- STRIDE, 1+MAX_PROG+2*MAX_CHECKS, ROM words per descriptor (derived)
- TV_AW, $clog2(NUM_TESTS*STRIDE), ROM address width (derived)
- IA_W, $clog2(IMEM_DEPTH), instruction memory address width (derived)
- FC_W, $clog2(NUM_TESTS*MAX_CHECKS+1), fail counter width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run; honoured only when not busy
- tv_addr  out  TV_AW  test-vector ROM address
- tv_data  in  XLEN  ROM read data, combinational from tv_addr
- cpu_reset  out  1  drives cpu reset
- imem_we  out  1  instruction memory write enable
- imem_waddr  out  IA_W  instruction memory word address
- imem_wdata  out  XLEN  instruction word
- rf_raddr  out  5  register-file debug read index
- rf_rdata  in  XLEN  register value, combinational from rf_raddr
- busy  out  1  run in progress
- done  out  1  run complete; held until next start
- pass  out  1  valid when done; 1 iff fail_count==0
- cur_test  out  $clog2(NUM_TESTS)  index of the test being run
- fail_count  out  FC_W  total mismatches in this run
- fail_test  out  $clog2(NUM_TESTS)  test index of the first mismatch
- fail_reg  out  5  register index of the first mismatch
- fail_got  out  XLEN  value read at the first mismatch
- fail_exp  out  XLEN  value expected at the first mismatch

Behaviour:
- Descriptor layout for test t, at base address t*STRIDE:
  - word 0: {prog_len[31:16], check_cnt[15:0]}
  - words 1..MAX_PROG: instructions
  - word 1+MAX_PROG+2k: register index in bits [4:0]
  - word 2+MAX_PROG+2k: expected value
- States and transitions:
  - IDLE: on start, go to HDR. Clear fail_count and the fail_* fields; set cur_test=0; set done=0.
  - HDR (1 cycle): tv_addr=base. Latch the clamped prog_len and check_cnt. Go to CLEAR.
  - CLEAR (IMEM_DEPTH cycles): imem_we=1, addr 0..IMEM_DEPTH-1, data 32'h00000013.
  - LOAD (prog_len cycles; skipped if 0): imem_we=1, addr i, data = ROM word base+1+i.
  - RUN (RUN_CYCLES cycles): cpu_reset=0, counter-timed.
  - CHECK (2 cycles per check; skipped if check_cnt=0):
    - phase A latches the register index;
    - phase B drives rf_raddr and the expected-value tv_addr, then compares;
    - on mismatch: fail_count++; the fail_* fields are written only if fail_count was 0.
  - NEXT (1 cycle): if cur_test==NUM_TESTS-1 go to DONE, else increment cur_test and go to HDR.
  - DONE: done=1, busy=0, cpu_reset stays 0 so registers remain inspectable. A start goes to HDR with counters cleared.
- cpu_reset:
  - 1 in IDLE, HDR, CLEAR, LOAD; 0 in RUN, CHECK, DONE.
  - The cpu keeps executing during CHECK. The NOP fill guarantees register state is stable after the program ends.
- busy is 1 in every state except IDLE and DONE.
- imem_we is 0 outside CLEAR and LOAD.
- start asserted while busy is ignored.
- Per-test latency is 1+IMEM_DEPTH+prog_len+RUN_CYCLES+2*check_cnt+1 cycles.
- fail_count saturates at its maximum value.
- Reset, at any time (including mid-LOAD or mid-RUN), gives:
  - state IDLE, cpu_reset=1;
  - imem_we=0, busy=0, done=0, pass=0;
  - all counters and fail_* outputs 0;
  - tv_addr, imem_waddr, imem_wdata, rf_raddr all 0.

Test Plan:
- Test 0 = addi x1,x0,1; addi x2,x0,2; add x3,x1,x2, with checks x1=1, x2=2, x3=3 (NUM_TESTS=1) -> done after 1+64+3+10+6+1=85 cycles; pass=1, fail_count=0.
- Same program with the x3 check expecting 4 -> pass=0, fail_count=1, fail_test=0, fail_reg=3, fail_got=3, fail_exp=4.
- Two tests: a 3-instruction program, then a 1-instruction program (addi x5,x0,7) checking x5=7 -> imem[1] and imem[2] read 0x00000013 during test 1; pass=1.
- prog_len=20, check_cnt=12 with default MAX_PROG/MAX_CHECKS -> exactly 16 LOAD writes and 8 checks; no ROM access beyond the descriptor.
- Assert reset for 1 cycle mid-LOAD -> next edge shows imem_we=0, cpu_reset=1, busy=0; a new start then runs to pass=1.
- Pulse start again 10 cycles into a run -> ignored: cur_test sequence and total cycle count unchanged.
